keypad_scanner_4x4: RTL and testbench

KEYPAD_SCANNER_4X4 -- requirements
Module: keypad_scanner_4x4

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scan_tick.sv | 27 ++
 rtl/keypad_scanner_4x4.sv | 129 ++++++++++++
 tb/tb_keypad_scanner_4x4.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad scanner definitions: FSM state codes, column one-hots, autorepeat timing.
// No logic; constants and a one-hot helper only.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SCAN     = 2'd0;
  localparam state_t ST_DEBOUNCE = 2'd1;
  localparam state_t ST_PRESSED  = 2'd2;
  localparam state_t ST_RELEASE  = 2'd3;

  localparam logic [3:0] COL0 = 4'b0001;
  localparam logic [3:0] COL1 = 4'b0010;
  localparam logic [3:0] COL2 = 4'b0100;
  localparam logic [3:0] COL3 = 4'b1000;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // Autorepeat timing in dwell ticks: first repeat, then the repeat period.
  localparam int unsigned REP_FIRST = 64;
  localparam int unsigned REP_NEXT  = 16;

  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Dwell timer: free-running SCAN_DIV-cycle period, tick high in the last cycle of each dwell.
// Latency: tick every SCAN_DIV cycles from reset release; no backpressure.
module keypad_scan_tick #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 keypad scanner: rotates column drive, debounces one-hot row sense, strobes {row,col} key code.
// Latency: 2 sync cycles + rest of dwell + DEBOUNCE_CNT dwells; no backpressure (key_valid is a strobe).
// Optional KEYPAD_SCAN_AUTOREPEAT_EN re-strobes a held key after 64 ticks, then every 16 ticks.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CNT);

  logic [3:0] rs_meta;
  logic [3:0] rs;
  logic       tick;
  state_t     state;
  logic [3:0] cap_row;
  logic [7:0] deb_cnt;
  logic [7:0] deb_nxt;
  logic [3:0] col_next;

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
  logic [6:0] rep_cnt;
  logic [6:0] rep_nxt;
  assign rep_nxt = rep_cnt + 7'd1;
`endif

  keypad_scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign deb_nxt  = deb_cnt + 8'd1;
  assign col_next = {col_drive[2:0], col_drive[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_meta   <= 4'd0;
      rs        <= 4'd0;
      state     <= ST_SCAN;
      col_drive <= COL0;
      cap_row   <= 4'd0;
      deb_cnt   <= 8'd0;
      key_data  <= KEY_NONE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
      rep_cnt   <= 7'd0;
`endif
    end else begin
      rs_meta   <= row_in;
      rs        <= rs_meta;
      key_valid <= 1'b0;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
      if (state != ST_PRESSED) begin
        rep_cnt <= 7'd0;
      end
`endif
      if (tick) begin
        case (state)
          ST_SCAN: begin
            // Zero or multi-bit rows are treated as no key and scanning continues.
            if (one_hot4(rs)) begin
              cap_row <= rs;
              deb_cnt <= 8'd0;
              state   <= ST_DEBOUNCE;
            end else begin
              col_drive <= col_next;
            end
          end
          ST_DEBOUNCE: begin
            if (rs == cap_row) begin
              deb_cnt <= deb_nxt;
              if (deb_nxt == DEB_LAST) begin
                key_data  <= {cap_row, col_drive};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= ST_PRESSED;
              end
            end else begin
              col_drive <= col_next;
              state     <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            if (rs == 4'd0) begin
              deb_cnt <= 8'd0;
              state   <= ST_RELEASE;
            end
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
            else if (rep_nxt == 7'(REP_FIRST)) begin
              // Rewind so the next hit is REP_NEXT ticks away.
              key_valid <= 1'b1;
              rep_cnt   <= 7'(REP_FIRST - REP_NEXT);
            end else begin
              rep_cnt <= rep_nxt;
            end
`endif
          end
          ST_RELEASE: begin
            if (rs == 4'd0) begin
              deb_cnt <= deb_nxt;
              if (deb_nxt == DEB_LAST) begin
                key_held  <= 1'b0;
                col_drive <= col_next;
                state     <= ST_SCAN;
              end
            end else begin
              state <= ST_PRESSED;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4 (SCAN_DIV=4, DEBOUNCE_CNT=3) driving a simulated key matrix.
// Directed timing steps followed by random presses, glitches and same-column double presses.
module tb_keypad_scanner_4x4;

  localparam int SD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_held;

  // Physical key matrix: bit r*4+c closes row r onto column c.
  logic [15:0] keys_down = 16'd0;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  logic prev_vld = 1'b0;

  keypad_scanner_4x4 #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_drive (col_drive),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && col_drive[c]) row_in[r] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor on the falling edge, clear of the DUT's active edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      chk("vld_one_cycle", {31'd0, prev_vld}, 32'd0);
      n_pulse++;
    end
    prev_vld = key_valid;
  end

  function automatic logic [7:0] code(input int r, input int c);
    logic [3:0] rb;
    logic [3:0] cb;
    rb = 4'b0001 << r;
    cb = 4'b0001 << c;
    return {rb, cb};
  endfunction

  // Cycle (counted from reset release) at which a key held since reset is accepted:
  // its column comes up after c dwells, is captured at the end of that dwell, then DC dwells.
  function automatic int accept_k(input int c);
    return SD * (c + 1) + SD * DC;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", {28'd0, col_drive}, 32'h1);
    chk("rst_data", {24'd0, key_data}, 32'h0);
    chk("rst_vld", {31'd0, key_valid}, 32'h0);
    chk("rst_held", {31'd0, key_held}, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    int a;
    int kinds;
    int r, c, r2, hold, gap;
    logic [7:0] last_key;
    int got_q[$];
    int exp_q[$];

    // Idle scan: columns rotate every SD cycles, no strobes.
    do_reset();
    n0 = n_pulse;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk("idle_col", {28'd0, col_drive}, 32'(4'b0001 << ((k / SD) % 4)));
    end
    chk("idle_no_vld", 32'(n_pulse - n0), 32'd0);

    // Key row3/col0 held from reset: exact acceptance and release timing.
    keys_down = 16'd0;
    keys_down[3*4+0] = 1'b1;
    do_reset();
    n0 = n_pulse;
    a = accept_k(0);
    for (int k = 1; k <= 92; k++) begin
      @(posedge clk); #1;
      if (k <= a + 1) chk("lat_vld", {31'd0, key_valid}, {31'd0, k == a});
      if (k == a) chk("lat_data", {24'd0, key_data}, 32'h81);
      if (k == a + 1) chk("lat_held", {31'd0, key_held}, 32'h1);
      if (k == 76) begin
        chk("hold_one_vld", 32'(n_pulse - n0), 32'd1);
        chk("hold_col", {28'd0, col_drive}, 32'h1);
        keys_down = 16'd0;
      end
      if (k == 91) chk("rel_held_still", {31'd0, key_held}, 32'h1);
      if (k == 92) begin
        chk("rel_held_clr", {31'd0, key_held}, 32'h0);
        chk("rel_col_adv", {28'd0, col_drive}, 32'h2);
      end
    end

    // Row2 bounces away after one debounce tick: no strobe, scan moves on.
    keys_down = 16'd0;
    keys_down[2*4+0] = 1'b1;
    do_reset();
    n0 = n_pulse;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 8) keys_down = 16'd0;
      if (k == 11) chk("bounce_col_held", {28'd0, col_drive}, 32'h1);
      if (k == 12) chk("bounce_col_next", {28'd0, col_drive}, 32'h2);
    end
    chk("bounce_no_vld", 32'(n_pulse - n0), 32'd0);

    // Two rows on column 1 (row_in 0110): ignored, scanning continues.
    keys_down = 16'd0;
    keys_down[1*4+1] = 1'b1;
    keys_down[2*4+1] = 1'b1;
    do_reset();
    n0 = n_pulse;
    repeat (40) @(posedge clk);
    #1;
    chk("multi_no_vld", 32'(n_pulse - n0), 32'd0);
    chk("multi_col", {28'd0, col_drive}, 32'(4'b0001 << ((40 / SD) % 4)));
    keys_down = 16'd0;

    // Reset in the middle of debouncing key 8'h18.
    keys_down[0*4+3] = 1'b1;
    do_reset();
    n0 = n_pulse;
    repeat (22) @(posedge clk);
    #1;
    chk("mid_deb_col", {28'd0, col_drive}, 32'h8);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_col", {28'd0, col_drive}, 32'h1);
    chk("abort_data", {24'd0, key_data}, 32'h0);
    chk("abort_held", {31'd0, key_held}, 32'h0);
    keys_down = 16'd0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("restart_col", {28'd0, col_drive}, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_vld", 32'(n_pulse - n0), 32'd0);

    // Key row1/col1 held 100 ticks past acceptance: repeats only when the option is built in.
    keys_down[1*4+1] = 1'b1;
    do_reset();
    a = accept_k(1);
    exp_q.push_back(a);
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    for (int t = 64; t <= 100; t += 16) exp_q.push_back(a + SD * t);
`endif
    for (int k = 1; k <= a + SD * 100; k++) begin
      @(posedge clk); #1;
      if (key_valid === 1'b1) begin
        got_q.push_back(k);
        chk("rep_data", {24'd0, key_data}, 32'h22);
      end
    end
    keys_down = 16'd0;
    chk("rep_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk("rep_time", 32'((i < got_q.size()) ? got_q[i] : -1), 32'(exp_q[i]));
    last_key = 8'h22;
    repeat (60) @(posedge clk);

    // Random presses (accepted), short glitches and same-column pairs (both ignored).
    for (int ev = 0; ev < 20; ev++) begin
      kinds = $urandom_range(0, 2);
      r     = $urandom_range(0, 3);
      c     = $urandom_range(0, 3);
      r2    = (r + $urandom_range(1, 3)) % 4;
      hold  = (kinds == 1) ? $urandom_range(1, 8) : $urandom_range(60, 150);
      gap   = $urandom_range(40, 80);
      n0    = n_pulse;
      #1;
      keys_down = 16'd0;
      keys_down[r*4+c] = 1'b1;
      if (kinds == 2) keys_down[r2*4+c] = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      chk("rnd_held", {31'd0, key_held}, {31'd0, kinds == 0});
      keys_down = 16'd0;
      repeat (gap) @(posedge clk);
      #1;
      if (kinds == 0) last_key = code(r, c);
      chk("rnd_vld_count", 32'(n_pulse - n0), 32'(kinds == 0 ? 1 : 0));
      chk("rnd_data", {24'd0, key_data}, {24'd0, last_key});
      chk("rnd_released", {31'd0, key_held}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
